pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath, the generic replacement for the fixed per-stage latches between IF/ID/EX/MEM/WB. Carries LANES data words plus destination register index and control bits downstream with a valid/ready handshake, synchronous flush (bubble insertion), optional skid buffer for full-throughput backpressure, and a saturating stall counter. One instance per stage boundary; the WB-side instance feeds the register-file write port.

---
 rtl/pipe_stage_reg_pkg.sv | 8 +
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg_stall_counter.sv | 14 +
 rtl/pipe_stage_reg.sv | 70 +++++++
 tb/tb_pipe_stage_reg.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared constants and state encoding for the pipeline stage register.
package pipe_pkg;
    localparam int WB_REGWR   = 1;
    localparam int WB_MEM2REG = 0;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream handshake bundle of one stage boundary.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [REG_W-1:0]        in_reg;
    logic [CTRL_W-1:0]       in_ctrl;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [REG_W-1:0]        out_reg;
    logic [CTRL_W-1:0]       out_ctrl;
    logic [CNT_W-1:0]        stall_cnt;
    modport master (
        output in_valid, in_data, in_reg, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_reg, out_ctrl, stall_cnt
    );
    modport slave (
        input  in_valid, in_data, in_reg, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_reg, out_ctrl, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg_stall_counter.sv
// stall_counter: saturating count of cycles the stage output is blocked; cleared only by reset.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush and stall counter.
// PIPE_SKID_EN adds a skid entry so in_ready is registered and throughput survives backpressure.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = 2,
    parameter int REG_W  = DEF_REG_W,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    pipe_stage_reg_if.slave  bus
);
    state_e                  state_q;
    logic [LANES*DATA_W-1:0] data_q;
    logic [REG_W-1:0]        reg_q;
    logic [CTRL_W-1:0]       ctrl_q;
    logic                    accept, handoff;
`ifdef PIPE_SKID_EN
    logic [LANES*DATA_W-1:0] skid_data_q;
    logic [REG_W-1:0]        skid_reg_q;
    logic [CTRL_W-1:0]       skid_ctrl_q;
    assign bus.in_ready = rst_n && state_q != ST_SKID;
`else
    assign bus.in_ready = rst_n && (!bus.out_valid || bus.out_ready);
`endif
    assign bus.out_valid = state_q != ST_EMPTY;
    assign accept        = bus.in_valid && bus.in_ready;
    assign handoff       = bus.out_valid && bus.out_ready;
    // ctrl is cleared on every path to EMPTY so a bubble never carries RegWrite
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            reg_q   <= '0;
            ctrl_q  <= '0;
`ifdef PIPE_SKID_EN
        end else if (accept && bus.out_valid && !bus.out_ready) begin
            state_q     <= ST_SKID;
            skid_data_q <= bus.in_data;
            skid_reg_q  <= bus.in_reg;
            skid_ctrl_q <= bus.in_ctrl;
        end else if (handoff && state_q == ST_SKID) begin
            state_q <= ST_FULL;
            data_q  <= skid_data_q;
            reg_q   <= skid_reg_q;
            ctrl_q  <= skid_ctrl_q;
`endif
        end else if (accept) begin
            state_q <= ST_FULL;
            data_q  <= bus.in_data;
            reg_q   <= bus.in_reg;
            ctrl_q  <= bus.in_ctrl;
        end else if (handoff) begin
            state_q <= ST_EMPTY;
            ctrl_q  <= '0;
        end
    end
    assign bus.out_data = data_q;
    assign bus.out_reg  = reg_q;
    assign bus.out_ctrl = ctrl_q;
    stall_counter #(.CNT_W(CNT_W)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (bus.out_valid && !bus.out_ready),
        .cnt_o (bus.stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: vector table plus scoreboard model of stage occupancy, handshake and stall count.
module tb_pipe_stage_reg;
    import pipe_pkg::*;
    localparam int DW = 32, LN = 2, RW = 5, CW = 2, NW = 16;
    typedef struct packed {
        logic [LN*DW-1:0] data;
        logic [RW-1:0]    rg;
        logic [CW-1:0]    ctrl;
    } word_t;
    typedef struct {
        logic  iv;
        word_t w;
        logic  ordy;
        logic  exp_valid;
        logic  exp_ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW)) bus ();
    pipe_stage_reg_if #(.DATA_W(DW), .LANES(LN), .REG_W(RW), .CTRL_W(CW), .CNT_W(4))  sbus ();

    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    pipe_stage_reg #(.DATA_W(DW), .LANES(LN), .REG_W(RW), .CTRL_W(CW), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    word_t       q[$];
    int unsigned stall_m = 0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t rnd_w();
        return word_t'({$urandom, $urandom, 5'($urandom), 2'($urandom)});
    endfunction

    task automatic drive(input logic iv, input word_t w, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = w.data;
        bus.in_reg    = w.rg;
        bus.in_ctrl   = w.ctrl;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    // one clock: drive, compare against the model, advance the model, step past the edge
    task automatic cycle(input logic iv, input word_t w, input logic ordy, input logic fl);
        logic rdy, acc, hnd;
        drive(iv, w, ordy, fl);
        #1;
`ifdef PIPE_SKID_EN
        rdy = q.size() < 2;
`else
        rdy = q.size() == 0 || ordy;
`endif
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(bus.out_data), 64'(q[0].data));
            chk("out_reg", 64'(bus.out_reg), 64'(q[0].rg));
            chk("out_ctrl", 64'(bus.out_ctrl), 64'(q[0].ctrl));
        end else begin
            chk("bubble_ctrl", 64'(bus.out_ctrl), 64'd0);
        end
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(stall_m));
        hnd = q.size() > 0 && ordy;
        acc = iv && rdy;
        if (q.size() > 0 && !ordy && stall_m != 32'hFFFF) stall_m++;
        if (fl) q.delete();
        else begin
            if (hnd) void'(q.pop_front());
            if (acc) q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        word_t idle, wa, wb, wc;
        idle = '0;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_reg = '0; sbus.in_ctrl = '0;
        sbus.flush = 1'b0; sbus.out_ready = 1'b0;
        drive(1'b0, idle, 1'b1, 1'b0);
        // vector table: first word, seven more back to back, then drain
        vecs[0] = '{1'b1, word_t'({32'h0000_00AA, 32'h1234_5678, 5'd9, 2'b10}), 1'b1, 1'b0, 1'b1};
        for (int i = 1; i < 8; i++) vecs[i] = '{1'b1, rnd_w(), 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, idle, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, idle, 1'b1, 1'b0, 1'b1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_reg", 64'(bus.out_reg), 64'd0);
        chk("rst_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("rst_stall", 64'(bus.stall_cnt), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].w, vecs[i].ordy, 1'b0);
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
            cycle(vecs[i].iv, vecs[i].w, vecs[i].ordy, 1'b0);
        end

        // backpressure: five blocked cycles with input still offered, then drain
        cycle(1'b1, rnd_w(), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd_w(), 1'b0, 1'b0);
        drive(1'b1, idle, 1'b0, 1'b0);
        #1;
        chk("bp_stall5", 64'(bus.stall_cnt), 64'd5);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1, 1'b0);

        // flush while holding two words (one in the single-entry build) with input offered
        wa = rnd_w(); wb = rnd_w(); wc = rnd_w();
        wa.ctrl = 2'b10; wb.ctrl = 2'b11; wc.ctrl = 2'b11;
        cycle(1'b1, wa, 1'b1, 1'b0);
        cycle(1'b1, wb, 1'b0, 1'b0);
        cycle(1'b1, wc, 1'b0, 1'b1);
        drive(1'b0, idle, 1'b0, 1'b0);
        #1;
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("fl_regwr", 64'(bus.out_ctrl[WB_REGWR]), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1, 1'b0);

        // flush beats a same-cycle accept and handoff
        cycle(1'b1, wa, 1'b1, 1'b0);
        cycle(1'b1, wb, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, idle, 1'b1, 1'b0);

        // narrow counter saturates at 15
        sbus.in_valid = 1'b1; sbus.in_ctrl = 2'b10;
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 10 || k == 15 || k == 16 || k == 20)
                chk($sformatf("sat_k%0d", k), 64'(sbus.stall_cnt), 64'(k < 15 ? k : 15));
        end
        chk("sat_valid", 64'(sbus.out_valid), 64'd1);

        // reset mid-stall with both entries occupied
        cycle(1'b1, rnd_w(), 1'b0, 1'b0);
        cycle(1'b1, rnd_w(), 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b0, idle, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        q.delete();
        stall_m = 0;
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_data", 64'(bus.out_data), 64'd0);
        chk("mrst_reg", 64'(bus.out_reg), 64'd0);
        chk("mrst_ctrl", 64'(bus.out_ctrl), 64'd0);
        chk("mrst_stall", 64'(bus.stall_cnt), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        cycle(1'b1, rnd_w(), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, idle, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
